// File: rtl/bip_control.sv
// -----------------------------------------------------------------------------
// bip_control
//   Instruction fetch/decode control unit for the 16-bit accumulator processor.
//   Fetches one instruction per FETCH/EXEC pair, decodes the 5-bit opcode and
//   drives the arithmetic unit op code, immediate operand, accumulator/operand
//   selects and the single-cycle data-memory/accumulator strobes. Owns the
//   program counter and the halt state.
//
//   Parameters:
//     PC_W    program counter width (wraps modulo 2^PC_W)
//     ADDR_W  data-memory address width, taken from instr[ADDR_W-1:0] (<= 11)
//
//   Ports:
//     i_clk          clock, rising edge
//     i_reset        synchronous reset, active-high
//     i_instr        instruction word: [15:11] opcode, [10:0] operand
//     i_instr_valid  i_instr valid this cycle
//     o_instr_req    fetch request (decode of the state register)
//     o_pc           current program counter
//     o_op           latched opcode to the arithmetic unit
//     o_imm          instr[10:0] sign-extended to 16 bits
//     o_addr         data-memory address
//     o_sel_acc      accumulator source: 0 data mem, 1 immediate, 2 ALU result
//     o_sel_data     ALU data operand: 0 data mem, 1 immediate
//     o_wr_acc       accumulator write enable (one EXEC cycle)
//     o_wr_ram       data-memory write enable (one EXEC cycle)
//     o_rd_ram       data-memory read enable (one EXEC cycle)
//     o_halted       high while halted
//
//   Build option:
//     BIP_ILLEGAL_TRAP_EN  when defined, undefined opcodes (01000-11111) halt
//                          the processor instead of executing as a NOP.
//
//   Handshake: an instruction is accepted on a rising edge where o_instr_req
//   and i_instr_valid are both high; i_instr_valid outside FETCH is ignored
//   and there is no back-pressure on the instruction source beyond o_instr_req.
// -----------------------------------------------------------------------------
module bip_control #(
    parameter int PC_W   = 11,
    parameter int ADDR_W = 11
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [15:0]       i_instr,
    input  logic              i_instr_valid,
    output logic              o_instr_req,
    output logic [PC_W-1:0]   o_pc,
    output logic [4:0]        o_op,
    output logic [15:0]       o_imm,
    output logic [ADDR_W-1:0] o_addr,
    output logic [1:0]        o_sel_acc,
    output logic              o_sel_data,
    output logic              o_wr_acc,
    output logic              o_wr_ram,
    output logic              o_rd_ram,
    output logic              o_halted
);

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    localparam logic [1:0] SEL_ACC_MEM = 2'd0;
    localparam logic [1:0] SEL_ACC_IMM = 2'd1;
    localparam logic [1:0] SEL_ACC_ALU = 2'd2;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [PC_W-1:0]   pc_next;
    logic [4:0]        op_next;
    logic [15:0]       imm_next;
    logic [ADDR_W-1:0] addr_next;
    logic [1:0]        sel_acc_next;
    logic              sel_data_next;
    logic              wr_acc_next;
    logic              wr_ram_next;
    logic              rd_ram_next;
    logic              halted_next;
    logic              trap_exec;

    // Undefined opcodes occupy the whole upper range 01000-11111.
`ifdef BIP_ILLEGAL_TRAP_EN
    assign trap_exec = (o_op[4:3] != 2'b00);
`else
    assign trap_exec = 1'b0;
`endif

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= ST_FETCH;
            o_pc       <= '0;
            o_op       <= '0;
            o_imm      <= '0;
            o_addr     <= '0;
            o_sel_acc  <= '0;
            o_sel_data <= 1'b0;
            o_wr_acc   <= 1'b0;
            o_wr_ram   <= 1'b0;
            o_rd_ram   <= 1'b0;
            o_halted   <= 1'b0;
        end else begin
            state      <= state_next;
            o_pc       <= pc_next;
            o_op       <= op_next;
            o_imm      <= imm_next;
            o_addr     <= addr_next;
            o_sel_acc  <= sel_acc_next;
            o_sel_data <= sel_data_next;
            o_wr_acc   <= wr_acc_next;
            o_wr_ram   <= wr_ram_next;
            o_rd_ram   <= rd_ram_next;
            o_halted   <= halted_next;
        end
    end

    // --------------------------------------------------------------- next state
    // o_op holds the opcode latched at fetch, so EXEC decides its successor
    // from it directly.
    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: if (i_instr_valid) state_next = ST_EXEC;
            ST_EXEC:  begin
                if (o_op == OP_HLT || trap_exec) state_next = ST_HALT;
                else                             state_next = ST_FETCH;
            end
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_FETCH;
        endcase
    end

    // ------------------------------------------------------------------ outputs
    // Operand fields and selects hold their last decoded value; the strobes
    // are only ever high for the single EXEC cycle after a fetch.
    always_comb begin
        pc_next       = o_pc;
        op_next       = o_op;
        imm_next      = o_imm;
        addr_next     = o_addr;
        sel_acc_next  = o_sel_acc;
        sel_data_next = o_sel_data;
        wr_acc_next   = 1'b0;
        wr_ram_next   = 1'b0;
        rd_ram_next   = 1'b0;
        halted_next   = (state_next == ST_HALT);

        if (state == ST_FETCH && i_instr_valid) begin
            op_next       = i_instr[15:11];
            imm_next      = {{5{i_instr[10]}}, i_instr[10:0]};
            addr_next     = i_instr[ADDR_W-1:0];
            sel_acc_next  = SEL_ACC_MEM;
            sel_data_next = 1'b0;
            case (i_instr[15:11])
                OP_STO: wr_ram_next = 1'b1;
                OP_LD: begin
                    wr_acc_next = 1'b1;
                    rd_ram_next = 1'b1;
                end
                OP_LDI: begin
                    sel_acc_next = SEL_ACC_IMM;
                    wr_acc_next  = 1'b1;
                end
                OP_ADD, OP_SUB: begin
                    sel_acc_next = SEL_ACC_ALU;
                    wr_acc_next  = 1'b1;
                    rd_ram_next  = 1'b1;
                end
                OP_ADDI, OP_SUBI: begin
                    sel_acc_next  = SEL_ACC_ALU;
                    sel_data_next = 1'b1;
                    wr_acc_next   = 1'b1;
                end
                default: ;  // HLT and undefined opcodes raise no strobes
            endcase
        end

        // PC advances only when EXEC returns to FETCH; a halt freezes it at
        // the address of the halting instruction.
        if (state == ST_EXEC && state_next == ST_FETCH)
            pc_next = o_pc + {{(PC_W-1){1'b0}}, 1'b1};
    end

    assign o_instr_req = (state == ST_FETCH);

endmodule
